// File: rtl/knight_seq_pkg.sv
// Shared definitions for the Knight command sequencer.
//   seq_state_t     : playback FSM states
//   err_code_t      : reason the last playback stopped early
//   POS_ACK_DEFAULT : response byte that acknowledges a command
//   CAL_GYRO, HDG_* : common command word / heading byte constants
package knight_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_DONE,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_NACK  = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_ABORT = 2'd3
  } err_code_t;

  localparam logic [7:0]  POS_ACK_DEFAULT = 8'hA5;

  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [7:0]  HDG_N    = 8'h00;
  localparam logic [7:0]  HDG_W    = 8'h3F;
  localparam logic [7:0]  HDG_S    = 8'h7F;
  localparam logic [7:0]  HDG_E    = 8'hBF;

endpackage

// File: rtl/knight_cmd_mem.sv
// Command list storage: DEPTH x 16-bit register file.
//   clk     : system clock
//   wr_en   : write wr_data into slot wr_addr on the rising edge
//   wr_addr : write slot
//   wr_data : command word to store
//   rd_addr : read slot (combinational read)
//   rd_data : command word at rd_addr
// Contents are deliberately not reset; the host reloads the list as needed.
module knight_cmd_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/knight_cmd_sequencer.sv
// Plays a programmed list of Knight commands through RemoteComm, one at a
// time, waiting for the positive ack before moving to the next slot.
//   clk, rst           : clock, synchronous active-high reset
//   wr_en/addr/data    : load a command slot (dropped while busy)
//   num_cmds, start    : number of commands to play, begin playback at slot 0
//   abort              : stop playback with err_code=abort
//   cmd, snd_cmd       : command word and 1-clk send strobe to RemoteComm
//   cmd_snt, resp_rdy  : RemoteComm status strobes
//   resp               : response byte from the Knight
//   busy, done, err    : playback status (done/err sticky until next start)
//   err_code           : 0 none, 1 nack, 2 timeout, 3 abort
//   cmd_idx            : slot in flight, or slot where playback stopped
module knight_cmd_sequencer
  import knight_seq_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter int         TMO_CLKS = 50_000_000,
  parameter logic [7:0] POS_ACK  = POS_ACK_DEFAULT,
  localparam int        AW       = $clog2(DEPTH),
  localparam int        TW       = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   num_cmds,
  input  logic          start,
  input  logic          abort,
  output logic [15:0]   cmd,
  output logic          snd_cmd,
  input  logic          cmd_snt,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] cmd_idx
);

  localparam logic [AW:0]   DEPTH_N  = DEPTH[AW:0];
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);

  // Index of the final slot to play: 0 plays one command, oversize requests
  // play the whole list.
  function automatic logic [AW-1:0] last_slot(input logic [AW:0] n);
    logic [AW:0] cnt;
    cnt = n;
    if (cnt == '0) begin
      cnt = {{AW{1'b0}}, 1'b1};
    end
    if (cnt > DEPTH_N) begin
      cnt = DEPTH_N;
    end
    return AW'(cnt - 1'b1);
  endfunction

  // Response timer stops at all-ones rather than wrapping back to zero.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  seq_state_t    state_q,    state_d;
  logic [15:0]   cmd_q,      cmd_d;
  logic          snd_cmd_q,  snd_cmd_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic          err_q,      err_d;
  err_code_t     err_code_q, err_code_d;
  logic [AW-1:0] cmd_idx_q,  cmd_idx_d;
  logic [AW-1:0] last_q,     last_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic [15:0]   mem_rd_data;

  knight_cmd_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en && !busy_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (cmd_idx_q),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    snd_cmd_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    cmd_idx_d  = cmd_idx_q;
    last_d     = last_q;
    timer_d    = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d     = last_slot(num_cmds);
          cmd_idx_d  = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cmd_d     = mem_rd_data;
        snd_cmd_d = 1'b1;
        state_d   = S_WAIT_SNT;
      end

      S_WAIT_SNT: begin
        if (cmd_snt) begin
          timer_d = '0;
          state_d = S_WAIT_RESP;
        end
      end

      S_WAIT_RESP: begin
        timer_d = sat_inc(timer_q);
        // A response arriving on the timeout clock still counts.
        if (resp_rdy) begin
          if (resp == POS_ACK) begin
            if (cmd_idx_q == last_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              cmd_idx_d = cmd_idx_q + 1'b1;
              state_d   = S_ISSUE;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
            busy_d     = 1'b0;
            state_d    = S_ERR;
          end
        end else if (timer_q == TMO_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          busy_d     = 1'b0;
          state_d    = S_ERR;
        end
      end

      S_DONE, S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other event while a command is being played.
    // DONE/ERR are single-clock terminal states and are left to finish.
    if (abort && (state_q inside {S_ISSUE, S_WAIT_SNT, S_WAIT_RESP})) begin
      cmd_d      = cmd_q;
      snd_cmd_d  = 1'b0;
      cmd_idx_d  = cmd_idx_q;
      timer_d    = timer_q;
      err_d      = 1'b1;
      err_code_d = ERR_ABORT;
      busy_d     = 1'b0;
      state_d    = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      snd_cmd_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cmd_idx_q  <= '0;
      last_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      snd_cmd_q  <= snd_cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cmd_idx_q  <= cmd_idx_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_cmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign cmd_idx  = cmd_idx_q;

endmodule

// File: tb/tb_knight_cmd_sequencer.sv
// Bench for knight_cmd_sequencer with a RemoteComm/Knight stub and a
// list-level reference model of playback outcome.
module tb_knight_cmd_sequencer;
  import knight_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, abort, cmd_snt, resp_rdy;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   num_cmds;
  logic [7:0]    resp;
  logic [15:0]   cmd;
  logic          snd_cmd, busy, done, err;
  logic [1:0]    err_code;
  logic [AW-1:0] cmd_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] ref_mem [DEPTH];
  logic [15:0] obs_q [$];
  int          snd_cyc_q [$];
  int          resp_cyc_q [$];

  int          snt_dly = 2;
  int          resp_dly = 3;
  int          silent_idx = -1;
  int          stub_n = 0;
  int          stub_k;
  bit          stub_busy = 1'b0;
  logic [7:0]  stub_resp [DEPTH];

  knight_cmd_sequencer #(
    .DEPTH    (DEPTH),
    .TMO_CLKS (TMO),
    .POS_ACK  (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .num_cmds (num_cmds),
    .start    (start),
    .abort    (abort),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .cmd_idx  (cmd_idx)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every command handed to RemoteComm.
  always @(negedge clk) begin
    if (snd_cmd === 1'b1) begin
      obs_q.push_back(cmd);
      snd_cyc_q.push_back(cyc);
    end
  end

  // RemoteComm + Knight stub: cmd_snt snt_dly clocks after snd_cmd, then the
  // scripted response resp_dly clocks after cmd_snt (or nothing if silent).
  initial begin
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    forever begin
      @(negedge clk);
      if (snd_cmd === 1'b1) begin
        stub_k    = stub_n;
        stub_n    = stub_n + 1;
        stub_busy = 1'b1;
        repeat (snt_dly) @(negedge clk);
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
        if (stub_k != silent_idx) begin
          repeat (resp_dly - 1) @(negedge clk);
          resp     = (stub_k < DEPTH) ? stub_resp[stub_k] : 8'hA5;
          resp_rdy = 1'b1;
          resp_cyc_q.push_back(cyc);
          @(negedge clk);
          resp_rdy = 1'b0;
        end
        stub_busy = 1'b0;
      end
    end
  end

  // Reference model: walk the list, stopping at the first slot the Knight
  // rejects or never answers.
  task automatic model(input int n_raw, output int n_iss, output bit e_done,
                       output bit e_err, output logic [1:0] e_code, output int e_idx);
    int n;
    n      = (n_raw == 0) ? 1 : ((n_raw > DEPTH) ? DEPTH : n_raw);
    e_done = 1'b0;
    e_err  = 1'b0;
    e_code = 2'd0;
    n_iss  = 0;
    e_idx  = 0;
    for (int i = 0; i < n; i++) begin
      n_iss = i + 1;
      e_idx = i;
      if (i == silent_idx) begin
        e_err = 1'b1; e_code = 2'd2; return;
      end
      if (stub_resp[i] != 8'hA5) begin
        e_err = 1'b1; e_code = 2'd1; return;
      end
    end
    e_done = 1'b1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic all_ack();
    for (int i = 0; i < DEPTH; i++) stub_resp[i] = 8'hA5;
    silent_idx = -1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    snd_cyc_q.delete();
    resp_cyc_q.delete();
    stub_n = 0;
  endtask

  task automatic start_pulse(input int n, input bit with_abort);
    @(negedge clk);
    num_cmds = n[AW:0];
    start    = 1'b1;
    abort    = with_abort;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_not_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_stub_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (stub_busy == 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cmd_snt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (cmd_snt === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic play(input int n, input bit with_abort, output bit ok);
    bit ok1, ok2;
    clear_obs();
    start_pulse(n, with_abort);
    wait_not_busy(ok1);
    wait_stub_idle(ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (cmd !== 16'h0) begin n_errors++; $display("FAIL rst_cmd: got %h want 0000", cmd); end
    n_checks++; if (snd_cmd !== 1'b0) begin n_errors++; $display("FAIL rst_snd: got %b want 0", snd_cmd); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if (err_code !== 2'd0) begin n_errors++; $display("FAIL rst_code: got %0d want 0", err_code); end
    n_checks++; if (cmd_idx !== '0) begin n_errors++; $display("FAIL rst_idx: got %0d want 0", cmd_idx); end
  endtask

  task automatic test_tour();
    bit ok1, ok2;
    logic [15:0] tour [5];
    tour = '{CAL_GYRO, 16'h57F4, 16'h5BF4, 16'h5004, 16'h53F4};
    for (int i = 0; i < 5; i++) load(i, tour[i]);
    all_ack();
    snt_dly = 3; resp_dly = 4;
    clear_obs();
    @(negedge clk);
    num_cmds = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1 || snd_cmd !== 1'b0) begin n_errors++; $display("FAIL tour_lat1: got busy=%b snd=%b want 1/0", busy, snd_cmd); end
    @(negedge clk);
    #1;
    n_checks++; if (snd_cmd !== 1'b1 || cmd !== CAL_GYRO) begin n_errors++; $display("FAIL tour_lat2: got snd=%b cmd=%h want 1/%h", snd_cmd, cmd, CAL_GYRO); end
    wait_not_busy(ok1);
    wait_stub_idle(ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_errors++; $display("FAIL tour_finish: got %b want 1", ok1 && ok2); end
    n_checks++; if (obs_q.size() != 5) begin n_errors++; $display("FAIL tour_count: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== tour[i]) begin n_errors++; $display("FAIL tour_cmd%0d: got %h want %h", i, obs_q[i], tour[i]); end
    end
    for (int i = 0; i < 4 && i + 1 < snd_cyc_q.size() && i < resp_cyc_q.size(); i++) begin
      n_checks++; if (snd_cyc_q[i+1] - resp_cyc_q[i] != 2) begin n_errors++; $display("FAIL tour_acklat%0d: got %0d want 2", i, snd_cyc_q[i+1] - resp_cyc_q[i]); end
    end
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL tour_status: got done=%b err=%b want 1/0", done, err); end
    n_checks++; if (cmd_idx !== 4'd4) begin n_errors++; $display("FAIL tour_idx: got %0d want 4", cmd_idx); end
  endtask

  task automatic test_nack();
    bit ok;
    all_ack();
    stub_resp[2] = 8'h5A;
    play(5, 1'b0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL nack_finish: got 0 want 1"); end
    n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_errors++; $display("FAIL nack_err: got err=%b code=%0d want 1/1", err, err_code); end
    n_checks++; if (cmd_idx !== 4'd2) begin n_errors++; $display("FAIL nack_idx: got %0d want 2", cmd_idx); end
    n_checks++; if (obs_q.size() != 3) begin n_errors++; $display("FAIL nack_count: got %0d want 3", obs_q.size()); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL nack_done: got %b want 0", done); end
    all_ack();
  endtask

  task automatic test_timeout();
    bit ok, ok2;
    int cnt;
    all_ack();
    silent_idx = 0;
    clear_obs();
    start_pulse(2, 1'b0);
    wait_cmd_snt(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tmo_snt: got 0 want 1"); end
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      cnt++;
      if (err_code === 2'd2) break;
    end
    // cnt counts clock edges from the one that samples cmd_snt (inclusive)
    // to the one that raises the timeout: that edge plus TMO further clocks.
    n_checks++; if (cnt != TMO + 1) begin n_errors++; $display("FAIL tmo_time: got %0d want %0d", cnt, TMO + 1); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b1) begin n_errors++; $display("FAIL tmo_status: got busy=%b err=%b want 0/1", busy, err); end
    n_checks++; if (cmd_idx !== 4'd0) begin n_errors++; $display("FAIL tmo_idx: got %0d want 0", cmd_idx); end
    wait_stub_idle(ok2);
    n_checks++; if (obs_q.size() != 1) begin n_errors++; $display("FAIL tmo_count: got %0d want 1", obs_q.size()); end
    all_ack();
  endtask

  task automatic test_abort();
    bit ok, ok2;
    all_ack();
    snt_dly = 20; resp_dly = 3;
    clear_obs();
    start_pulse(3, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() == 2) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_reach: got 0 want 1"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1 || err_code !== 2'd3) begin n_errors++; $display("FAIL abort_err: got err=%b code=%0d want 1/3", err, err_code); end
    n_checks++; if (busy !== 1'b0 || cmd_idx !== 4'd1) begin n_errors++; $display("FAIL abort_state: got busy=%b idx=%0d want 0/1", busy, cmd_idx); end
    wait_stub_idle(ok2);
    repeat (5) @(negedge clk);
    n_checks++; if (obs_q.size() != 2) begin n_errors++; $display("FAIL abort_count: got %0d want 2", obs_q.size()); end
    // abort while idle leaves the sticky error untouched
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got err=%b code=%0d busy=%b want 1/3/0", err, err_code, busy); end
    // start together with abort: start wins, replay from slot 0
    snt_dly = 2;
    play(3, 1'b1, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_replay_finish: got 0 want 1"); end
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || err_code !== 2'd0) begin n_errors++; $display("FAIL abort_replay: got done=%b err=%b code=%0d want 1/0/0", done, err, err_code); end
    n_checks++; if (obs_q.size() != 3) begin n_errors++; $display("FAIL abort_replay_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== ref_mem[i]) begin n_errors++; $display("FAIL abort_replay_cmd%0d: got %h want %h", i, obs_q[i], ref_mem[i]); end
    end
  endtask

  task automatic test_coincident();
    bit ok, ok1, ok2;
    logic [15:0] orig1;
    all_ack();
    snt_dly = 2; resp_dly = TMO;
    orig1 = ref_mem[1];
    clear_obs();
    start_pulse(2, 1'b0);
    wait_cmd_snt(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL coin_snt: got 0 want 1"); end
    repeat (3) @(negedge clk);
    start = 1'b1; num_cmds = 5'd1;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = ~orig1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_not_busy(ok1);
    wait_stub_idle(ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_errors++; $display("FAIL coin_finish: got 0 want 1"); end
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL coin_ack: got done=%b err=%b code=%0d want 1/0", done, err, err_code); end
    n_checks++; if (obs_q.size() != 2) begin n_errors++; $display("FAIL coin_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_checks++; if (obs_q[0] !== ref_mem[0]) begin n_errors++; $display("FAIL coin_cmd0: got %h want %h", obs_q[0], ref_mem[0]); end
      n_checks++; if (obs_q[1] !== orig1) begin n_errors++; $display("FAIL coin_wrbusy: got %h want %h", obs_q[1], orig1); end
    end
    resp_dly = 3;
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    all_ack();
    snt_dly = 2; resp_dly = 30;
    clear_obs();
    start_pulse(3, 1'b0);
    wait_cmd_snt(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rmid_snt: got 0 want 1"); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || snd_cmd !== 1'b0) begin n_errors++; $display("FAIL rmid_flags: got busy=%b done=%b err=%b snd=%b want 0", busy, done, err, snd_cmd); end
    n_checks++; if (cmd !== 16'h0 || err_code !== 2'd0 || cmd_idx !== '0) begin n_errors++; $display("FAIL rmid_data: got cmd=%h code=%0d idx=%0d want 0", cmd, err_code, cmd_idx); end
    wait_stub_idle(ok2);
    resp_dly = 3;
    play(3, 1'b0, ok);
    n_checks++; if (!ok || done !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL rmid_replay: got ok=%b done=%b err=%b want 1/1/0", ok, done, err); end
    n_checks++; if (obs_q.size() != 3) begin n_errors++; $display("FAIL rmid_count: got %0d want 3", obs_q.size()); end
  endtask

  task automatic test_random();
    bit ok, e_done, e_err;
    logic [1:0] e_code;
    int n, n_iss, e_idx, nk;
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < DEPTH; s++) load(s, 16'($urandom));
      all_ack();
      n = (it == 0) ? 0 : ((it == 1) ? 20 : int'($urandom_range(1, 31)));
      if ($urandom_range(0, 1) == 1) begin
        nk = $urandom_range(0, DEPTH - 1);
        b  = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        stub_resp[nk] = b;
      end
      snt_dly  = $urandom_range(1, 4);
      resp_dly = $urandom_range(1, 12);
      model(n, n_iss, e_done, e_err, e_code, e_idx);
      play(n, 1'b0, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL rnd%0d_finish: got 0 want 1", it); end
      n_checks++; if (done !== e_done || err !== e_err || err_code !== e_code) begin n_errors++; $display("FAIL rnd%0d_status: got %b%b%0d want %b%b%0d", it, done, err, err_code, e_done, e_err, e_code); end
      n_checks++; if (cmd_idx !== e_idx[AW-1:0]) begin n_errors++; $display("FAIL rnd%0d_idx: got %0d want %0d", it, cmd_idx, e_idx); end
      n_checks++; if (obs_q.size() != n_iss) begin n_errors++; $display("FAIL rnd%0d_count: got %0d want %0d", it, obs_q.size(), n_iss); end
      for (int i = 0; i < n_iss && i < obs_q.size(); i++) begin
        n_checks++; if (obs_q[i] !== ref_mem[i]) begin n_errors++; $display("FAIL rnd%0d_cmd%0d: got %h want %h", it, i, obs_q[i], ref_mem[i]); end
      end
    end
    all_ack();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    num_cmds = '0; start = 1'b0; abort = 1'b0;
    all_ack();
    test_reset();
    test_tour();
    test_nack();
    test_timeout();
    test_abort();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
